// File: rtl/enigma_pkg.sv
// Shared types and constants for the rotor stack.
// Letter codes, stepper states and a position clamp helper.
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam int NUM_LETTERS = 26;

    localparam letter_t L_A = 5'd0;
    localparam letter_t L_B = 5'd1;
    localparam letter_t L_C = 5'd2;
    localparam letter_t L_D = 5'd3;
    localparam letter_t L_E = 5'd4;
    localparam letter_t L_F = 5'd5;
    localparam letter_t L_G = 5'd6;
    localparam letter_t L_H = 5'd7;
    localparam letter_t L_I = 5'd8;
    localparam letter_t L_J = 5'd9;
    localparam letter_t L_K = 5'd10;
    localparam letter_t L_L = 5'd11;
    localparam letter_t L_M = 5'd12;
    localparam letter_t L_N = 5'd13;
    localparam letter_t L_O = 5'd14;
    localparam letter_t L_P = 5'd15;
    localparam letter_t L_Q = 5'd16;
    localparam letter_t L_R = 5'd17;
    localparam letter_t L_S = 5'd18;
    localparam letter_t L_T = 5'd19;
    localparam letter_t L_U = 5'd20;
    localparam letter_t L_V = 5'd21;
    localparam letter_t L_W = 5'd22;
    localparam letter_t L_X = 5'd23;
    localparam letter_t L_Y = 5'd24;
    localparam letter_t L_Z = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_PRESENT
    } step_state_t;

    // Codes outside A..Z collapse to A.
    function automatic letter_t clamp_letter(input letter_t x);
        return (x > L_Z) ? L_A : x;
    endfunction

endpackage

// File: rtl/mod26_inc.sv
// Rotor position increment modulo 26.
// Z wraps to A; any out-of-range code also lands on A.
module mod26_inc
    import enigma_pkg::*;
(
    input  letter_t a,
    output letter_t y
);

    assign y = (a >= L_Z) ? L_A : a + 5'd1;

endmodule

// File: rtl/rotor_stepper.sv
// Keypress front end: Enigma rotor stepping with double step,
// then presents the letter one-hot to the rotor chain.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter letter_t NOTCH_R = 5'd16,
    parameter letter_t NOTCH_M = 5'd4,
    parameter letter_t NOTCH_L = 5'd21
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        key_valid,
    input  logic [4:0]  key_letter,
    output logic        key_ready,
    input  logic        load,
    input  logic [14:0] load_pos,
    output logic [4:0]  pos_r,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_l,
    output logic        rotate_r,
    output logic        rotate_m,
    output logic        rotate_l,
    output logic [25:0] letter_onehot,
    output logic        letter_valid,
    input  logic        letter_ready,
    output logic        bad_key,
    output logic        at_notch_l
);

    step_state_t state_q, state_d;
    letter_t     pos_r_q, pos_r_d;
    letter_t     pos_m_q, pos_m_d;
    letter_t     pos_l_q, pos_l_d;
    letter_t     letter_q, letter_d;
    logic        rot_r_q, rot_r_d;
    logic        rot_m_q, rot_m_d;
    logic        rot_l_q, rot_l_d;
    logic        valid_q, valid_d;
    logic [25:0] onehot_q, onehot_d;
    logic        bad_q, bad_d;
    letter_t     inc_r, inc_m, inc_l;

    mod26_inc u_inc_r (.a(pos_r_q), .y(inc_r));
    mod26_inc u_inc_m (.a(pos_m_q), .y(inc_m));
    mod26_inc u_inc_l (.a(pos_l_q), .y(inc_l));

    // Step decisions are taken at accept time from the pre-step
    // positions, so the rotate pulses line up with the STEP cycle.
    always_comb begin
        state_d  = state_q;
        pos_r_d  = pos_r_q;
        pos_m_d  = pos_m_q;
        pos_l_d  = pos_l_q;
        letter_d = letter_q;
        rot_r_d  = 1'b0;
        rot_m_d  = 1'b0;
        rot_l_d  = 1'b0;
        valid_d  = 1'b0;
        onehot_d = '0;
        bad_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pos_l_d = clamp_letter(load_pos[14:10]);
                    pos_m_d = clamp_letter(load_pos[9:5]);
                    pos_r_d = clamp_letter(load_pos[4:0]);
                end else if (key_valid) begin
                    if (key_letter <= L_Z) begin
                        letter_d = key_letter;
                        rot_r_d  = 1'b1;
                        rot_m_d  = (pos_r_q == NOTCH_R)
                                 || (pos_m_q == NOTCH_M);
                        rot_l_d  = (pos_m_q == NOTCH_M);
                        state_d  = ST_STEP;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (rot_r_q) pos_r_d = inc_r;
                if (rot_m_q) pos_m_d = inc_m;
                if (rot_l_q) pos_l_d = inc_l;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                valid_d  = 1'b1;
                onehot_d = 26'd1 << letter_q;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (letter_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    valid_d  = 1'b1;
                    onehot_d = onehot_q;
                end
            end
        endcase
    end

    // State, positions and all registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            pos_r_q  <= L_A;
            pos_m_q  <= L_A;
            pos_l_q  <= L_A;
            letter_q <= L_A;
            rot_r_q  <= 1'b0;
            rot_m_q  <= 1'b0;
            rot_l_q  <= 1'b0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_r_q  <= pos_r_d;
            pos_m_q  <= pos_m_d;
            pos_l_q  <= pos_l_d;
            letter_q <= letter_d;
            rot_r_q  <= rot_r_d;
            rot_m_q  <= rot_m_d;
            rot_l_q  <= rot_l_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            bad_q    <= bad_d;
        end
    end

    assign key_ready     = (state_q == ST_IDLE);
    assign at_notch_l    = (pos_l_q == NOTCH_L);
    assign pos_r         = pos_r_q;
    assign pos_m         = pos_m_q;
    assign pos_l         = pos_l_q;
    assign rotate_r      = rot_r_q;
    assign rotate_m      = rot_m_q;
    assign rotate_l      = rot_l_q;
    assign letter_valid  = valid_q;
    assign letter_onehot = onehot_q;
    assign bad_key       = bad_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard bench for rotor_stepper.
// Directed keypresses with hand-computed rotor positions.
module tb_rotor_stepper;

    logic        clock = 1'b0;
    logic        resetn;
    logic        key_valid;
    logic [4:0]  key_letter;
    logic        key_ready;
    logic        load;
    logic [14:0] load_pos;
    logic [4:0]  pos_r, pos_m, pos_l;
    logic        rotate_r, rotate_m, rotate_l;
    logic [25:0] letter_onehot;
    logic        letter_valid;
    logic        letter_ready;
    logic        bad_key;
    logic        at_notch_l;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic r, m, l;
    } rot_exp_t;

    typedef struct packed {
        logic [25:0] oh;
        logic [4:0]  r, m, l;
    } let_exp_t;

    rot_exp_t rot_q[$];
    let_exp_t let_q[$];

    rotor_stepper dut (
        .clock(clock), .resetn(resetn),
        .key_valid(key_valid), .key_letter(key_letter),
        .key_ready(key_ready), .load(load), .load_pos(load_pos),
        .pos_r(pos_r), .pos_m(pos_m), .pos_l(pos_l),
        .rotate_r(rotate_r), .rotate_m(rotate_m),
        .rotate_l(rotate_l), .letter_onehot(letter_onehot),
        .letter_valid(letter_valid), .letter_ready(letter_ready),
        .bad_key(bad_key), .at_notch_l(at_notch_l)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents something.
    always @(negedge clock) begin
        if (resetn) begin
            if (rotate_r || rotate_m || rotate_l) begin
                if (rot_q.size() == 0) begin
                    chk("unexpected_rotate",
                        {29'd0, rotate_r, rotate_m, rotate_l}, 32'd0);
                end else begin
                    rot_exp_t e;
                    e = rot_q.pop_front();
                    chk("rotate_rml",
                        {29'd0, rotate_r, rotate_m, rotate_l},
                        {29'd0, e.r, e.m, e.l});
                end
            end
            if (letter_valid && letter_ready) begin
                if (let_q.size() == 0) begin
                    chk("unexpected_letter", {6'd0, letter_onehot}, 32'd0);
                end else begin
                    let_exp_t e;
                    e = let_q.pop_front();
                    chk("letter_onehot", {6'd0, letter_onehot},
                        {6'd0, e.oh});
                    chk("positions_lmr", {17'd0, pos_l, pos_m, pos_r},
                        {17'd0, e.l, e.m, e.r});
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [14:0] lp);
        load     = 1'b1;
        load_pos = lp;
        step_clk();
        load     = 1'b0;
    endtask

    // Offer a key in IDLE and push its expected response.
    task automatic accept(input logic [4:0] k,
                          input logic [4:0] er, em, el,
                          input logic rr, rm, rl);
        rot_exp_t re;
        let_exp_t le;
        re = '{r: rr, m: rm, l: rl};
        le = '{oh: 26'd1 << k, r: er, m: em, l: el};
        rot_q.push_back(re);
        let_q.push_back(le);
        chk("key_ready_idle", {31'd0, key_ready}, 32'd1);
        key_valid  = 1'b1;
        key_letter = k;
        step_clk();
        key_valid  = 1'b0;
    endtask

    // Run the rest of a transaction; optionally stall the consumer.
    task automatic complete(input int hold);
        logic [25:0] held;
        int guard;
        letter_ready = (hold == 0);
        step_clk();
        chk("valid_cycle2", {31'd0, letter_valid}, 32'd0);
        step_clk();
        chk("valid_cycle3", {31'd0, letter_valid}, 32'd1);
        guard = 0;
        while (!letter_valid && guard < 10) begin
            step_clk();
            guard++;
        end
        if (guard == 10) chk("valid_timeout", 32'd1, 32'd0);
        held = letter_onehot;
        if (hold > 0) begin
            key_valid  = 1'b1;
            key_letter = 5'd9;
            for (int i = 0; i < hold; i++) begin
                chk("hold_ready_low", {31'd0, key_ready}, 32'd0);
                chk("hold_onehot", {6'd0, letter_onehot}, {6'd0, held});
                step_clk();
            end
            key_valid    = 1'b0;
            letter_ready = 1'b1;
        end
        step_clk();
        chk("ready_after_hs", {31'd0, key_ready}, 32'd1);
        chk("valid_after_hs", {31'd0, letter_valid}, 32'd0);
    endtask

    initial begin
        resetn       = 1'b0;
        key_valid    = 1'b0;
        key_letter   = '0;
        load         = 1'b0;
        load_pos     = '0;
        letter_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pos", {17'd0, pos_l, pos_m, pos_r}, 32'd0);
        chk("rst_outs", {rotate_r, rotate_m, rotate_l, letter_valid,
                         bad_key, 1'b0, letter_onehot}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        step_clk();
        chk("rst_key_ready", {31'd0, key_ready}, 32'd1);

        // A from 0,0,0: right only
        accept(5'd0, 5'd1, 5'd0, 5'd0, 1, 0, 0);
        complete(0);

        // Right at notch Q, then middle at E: double step
        do_load({5'd0, 5'd3, 5'd16});
        chk("load_pos", {17'd0, pos_l, pos_m, pos_r},
            {17'd0, 5'd0, 5'd3, 5'd16});
        accept(5'd7, 5'd17, 5'd4, 5'd0, 1, 1, 0);
        complete(0);
        accept(5'd25, 5'd18, 5'd5, 5'd1, 1, 1, 1);
        complete(0);

        // Wrap 25->0, held consumer, then immediate next accept
        do_load({5'd25, 5'd25, 5'd25});
        accept(5'd2, 5'd0, 5'd25, 5'd25, 1, 0, 0);
        complete(5);
        accept(5'd12, 5'd1, 5'd25, 5'd25, 1, 0, 0);
        complete(0);

        // Out-of-range key
        key_valid  = 1'b1;
        key_letter = 5'd30;
        step_clk();
        key_valid  = 1'b0;
        chk("bad_key_pulse", {31'd0, bad_key}, 32'd1);
        chk("bad_key_ready", {31'd0, key_ready}, 32'd1);
        chk("bad_key_pos", {17'd0, pos_l, pos_m, pos_r},
            {17'd0, 5'd25, 5'd25, 5'd1});
        step_clk();
        chk("bad_key_once", {31'd0, bad_key}, 32'd0);
        chk("bad_key_novalid", {31'd0, letter_valid}, 32'd0);

        // Left notch indicator
        do_load({5'd21, 5'd0, 5'd0});
        chk("at_notch_l", {31'd0, at_notch_l}, 32'd1);

        // Load wins over a simultaneous key, key stays pending
        load       = 1'b1;
        load_pos   = {5'd21, 5'd0, 5'd5};
        key_valid  = 1'b1;
        key_letter = 5'd3;
        step_clk();
        load = 1'b0;
        chk("load_prio_pos", {27'd0, pos_r}, 32'd5);
        chk("load_prio_idle", {31'd0, key_ready}, 32'd1);
        chk("load_prio_norot", {31'd0, rotate_r}, 32'd0);
        accept(5'd3, 5'd6, 5'd0, 5'd21, 1, 0, 0);
        complete(0);
        chk("notch_l_kept", {31'd0, at_notch_l}, 32'd1);

        // Out-of-range load fields
        do_load({5'd26, 5'd30, 5'd31});
        chk("load_clamp", {17'd0, pos_l, pos_m, pos_r}, 32'd0);

        // Reset during SETTLE aborts the transaction
        do_load({5'd2, 5'd4, 5'd16});
        accept(5'd4, 5'd17, 5'd5, 5'd3, 1, 1, 1);
        step_clk();
        resetn = 1'b0;
        #1;
        chk("mid_rst_pos", {17'd0, pos_l, pos_m, pos_r}, 32'd0);
        chk("mid_rst_outs", {rotate_r, rotate_m, rotate_l,
                             letter_valid, bad_key, 1'b0,
                             letter_onehot}, 32'd0);
        let_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) step_clk();
        chk("mid_rst_novalid", {31'd0, letter_valid}, 32'd0);
        accept(5'd9, 5'd1, 5'd0, 5'd0, 1, 0, 0);
        complete(0);

        repeat (2) step_clk();
        chk("rot_q_drained", rot_q.size(), 32'd0);
        chk("let_q_drained", let_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
